// File: rtl/alu_issue_ctrl.sv
// Command-issue / result-return stage in front of a registered scalar ALU.
// Optional divide-by-zero trap enabled by defining ALU_ISSUE_DIVZ_TRAP_EN.
module alu_issue_ctrl #(
  parameter int unsigned DATA_IN_WIDTH  = 32,
  parameter int unsigned OP_CODE_WIDTH  = 4,
  parameter int unsigned DATA_OUT_WIDTH = 64,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DATA_IN_WIDTH-1:0]  cmd_a,
  input  logic [DATA_IN_WIDTH-1:0]  cmd_b,
  input  logic [OP_CODE_WIDTH-1:0]  cmd_op,
  input  logic [TAG_WIDTH-1:0]      cmd_tag,
  output logic [DATA_IN_WIDTH-1:0]  alu_a,
  output logic [DATA_IN_WIDTH-1:0]  alu_b,
  output logic [OP_CODE_WIDTH-1:0]  alu_op,
  input  logic [DATA_OUT_WIDTH-1:0] alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_OUT_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned CPW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RPW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RCW   = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned CRW   = RCW + 1;
  localparam int unsigned CMD_W = 2 * DATA_IN_WIDTH + OP_CODE_WIDTH + TAG_WIDTH;

  // Command FIFO
  logic [CMD_W-1:0]         cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]           cmd_wr_q, cmd_rd_q;
  logic [CCW-1:0]           cmd_cnt_q, cmd_cnt_d;
  logic                     cmd_ready_q;
  logic                     cmd_push, issue;
  logic [DATA_IN_WIDTH-1:0] head_a, head_b;
  logic [OP_CODE_WIDTH-1:0] head_op;
  logic [TAG_WIDTH-1:0]     head_tag;
  logic                     head_trap;

  // In-flight pipeline and response FIFO
  logic                      s0_valid_q, s1_valid_q, s0_err_q, s1_err_q;
  logic [TAG_WIDTH-1:0]      s0_tag_q, s1_tag_q;
  logic [DATA_OUT_WIDTH-1:0] rsp_data_mem [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]      rsp_tag_mem  [RSP_DEPTH];
  logic                      rsp_err_mem  [RSP_DEPTH];
  logic [RPW-1:0]            rsp_wr_q, rsp_rd_q;
  logic [RCW-1:0]            rsp_cnt_q, rsp_cnt_d;
  logic [CRW-1:0]            credit;
  logic                      rsp_push, rsp_pop;

  logic [DATA_IN_WIDTH-1:0]  alu_a_q, alu_b_q;
  logic [OP_CODE_WIDTH-1:0]  alu_op_q;

  function automatic logic [CPW-1:0] cmd_inc(input logic [CPW-1:0] p);
    return (p == CPW'(CMD_DEPTH - 1)) ? '0 : p + CPW'(1);
  endfunction

  function automatic logic [RPW-1:0] rsp_inc(input logic [RPW-1:0] p);
    return (p == RPW'(RSP_DEPTH - 1)) ? '0 : p + RPW'(1);
  endfunction

  assign {head_a, head_b, head_op, head_tag} = cmd_mem[cmd_rd_q];

`ifdef ALU_ISSUE_DIVZ_TRAP_EN
  assign head_trap = (head_op == OP_CODE_WIDTH'(4'b0011)) && (head_b == '0);
`else
  assign head_trap = 1'b0;
`endif

  // Responses already buffered plus those still in the ALU bound what may be issued.
  assign credit   = CRW'(rsp_cnt_q) + CRW'(s0_valid_q) + CRW'(s1_valid_q);
  assign cmd_push = cmd_valid & cmd_ready_q;
  assign issue    = (cmd_cnt_q != '0) && (credit < CRW'(RSP_DEPTH));
  assign rsp_push = s1_valid_q;
  assign rsp_pop  = rsp_valid & rsp_ready;

  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    unique case ({cmd_push, issue})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase
    rsp_cnt_d = rsp_cnt_q;
    unique case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + RCW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - RCW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_q] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      s0_valid_q  <= 1'b0;
      s0_tag_q    <= '0;
      s0_err_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_err_q    <= 1'b0;
    end else begin
      cmd_cnt_q   <= cmd_cnt_d;
      cmd_ready_q <= (cmd_cnt_d < CCW'(CMD_DEPTH));
      if (cmd_push) cmd_wr_q <= cmd_inc(cmd_wr_q);
      if (issue) begin
        cmd_rd_q <= cmd_inc(cmd_rd_q);
        alu_a_q  <= head_a;
        alu_b_q  <= head_b;
        alu_op_q <= head_trap ? '0 : head_op;
      end
      s0_valid_q <= issue;
      s0_tag_q   <= head_tag;
      s0_err_q   <= issue & head_trap;
      s1_valid_q <= s0_valid_q;
      s1_tag_q   <= s0_tag_q;
      s1_err_q   <= s0_err_q;
    end
  end

  // Storage is reset so the response outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        rsp_data_mem[i] <= '0;
        rsp_tag_mem[i]  <= '0;
        rsp_err_mem[i]  <= 1'b0;
      end
    end else begin
      rsp_cnt_q <= rsp_cnt_d;
      if (rsp_push) begin
        rsp_data_mem[rsp_wr_q] <= s1_err_q ? '0 : alu_result;
        rsp_tag_mem[rsp_wr_q]  <= s1_tag_q;
        rsp_err_mem[rsp_wr_q]  <= s1_err_q;
        rsp_wr_q               <= rsp_inc(rsp_wr_q);
      end
      if (rsp_pop) rsp_rd_q <= rsp_inc(rsp_rd_q);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_data  = rsp_data_mem[rsp_rd_q];
  assign rsp_tag   = rsp_tag_mem[rsp_rd_q];
  assign rsp_err   = rsp_err_mem[rsp_rd_q];
  assign busy      = (cmd_cnt_q != '0) | s0_valid_q | s1_valid_q | (rsp_cnt_q != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed steps plus randomized traffic
// against a queue-based reference; includes a behavioural registered ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op, cmd_tag;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err, busy;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  function automatic logic [63:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return {32'd0, a} + {32'd0, b};
      4'd1:    return {32'd0, a} - {32'd0, b};
      4'd2:    return {32'd0, a} * {32'd0, b};
      4'd3:    return (b == 32'd0) ? 64'd0 : {32'd0, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_a, alu_b, alu_op);

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
    logic        e;
  } rsp_t;

  rsp_t        exp_q[$];
  int          vec = 0, miss = 0, cyc = 0, pops = 0, pop_first = -1, pop_last = -1;
  int          k, lat;
  logic        last_acc, hold_prev = 1'b0;
  logic [63:0] hold_d;
  logic [3:0]  hold_t;
  logic        hold_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [3:0] tag);
    rsp_t r;
    logic trap;
`ifdef ALU_ISSUE_DIVZ_TRAP_EN
    trap = (op == 4'b0011) && (b == 32'd0);
`else
    trap = 1'b0;
`endif
    r.d = trap ? 64'd0 : alu_f(a, b, op);
    r.t = tag;
    r.e = trap;
    return r;
  endfunction

  // One clock: observe handshakes mid-cycle, update the reference, return #1 after the edge.
  task automatic tick();
    rsp_t e;
    logic pop;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", rsp_data, hold_d);
      chk("hold_tag_err", {59'd0, rsp_tag, rsp_err}, {59'd0, hold_t, hold_e});
    end
    hold_prev = rsp_valid && !rsp_ready;
    hold_d = rsp_data; hold_t = rsp_tag; hold_e = rsp_err;
    last_acc = cmd_valid && cmd_ready;
    pop = rsp_valid && rsp_ready;
    if (pop) begin
      pops++;
      if (pop_first < 0) pop_first = cyc;
      pop_last = cyc;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_tag", 64'(rsp_tag), 64'(e.t));
        chk("rsp_err", 64'(rsp_err), 64'(e.e));
      end
    end
    if (last_acc) exp_q.push_back(model(cmd_a, cmd_b, cmd_op, cmd_tag));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_regs", {alu_a, alu_b} ^ 64'(alu_op), 64'd0);
    chk("rst_rsp_out", rsp_data | 64'(rsp_tag) | 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1 chk("cmd_ready_after_release", 64'(cmd_ready), 64'd0);
    tick();
    chk("cmd_ready_one_cycle", 64'(cmd_ready), 64'd1);

    // Single command, minimum latency.
    drive(1'b1, 32'd5, 32'd7, 4'b0000, 4'd3);
    tick();
    chk("single_accept", 64'(last_acc), 64'd1);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("single_data", rsp_data, 64'd12);
    rsp_ready = 1'b1;
    tick();
    chk("busy_after_pop", 64'(busy), 64'd0);

    // Back-to-back stream, no bubbles.
    pops = 0; pop_first = -1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'd2, 4'b0010, 4'(i));
      tick();
      if (last_acc) k++;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("b2b_accepts", 64'(k), 64'd8);
    chk("b2b_pops", 64'(pops), 64'd8);
    chk("b2b_no_bubbles", 64'(pop_last - pop_first), 64'd7);

    // Backpressure: fill both FIFOs, then drain (includes full-FIFO issue/push overlap).
    rsp_ready = 1'b0;
    pops = 0;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      drive(k < 10, 32'(100 + k), 32'(k), 4'd0, 4'(k));
      tick();
      if (last_acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd8);
    chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_no_pops", 64'(pops), 64'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && (k < 10 || exp_q.size() > 0); c++) begin
      drive(k < 10, 32'(100 + k), 32'(k), 4'd0, 4'(k));
      tick();
      if (last_acc) k++;
    end
    cmd_valid = 1'b0;
    chk("bp_all_accepted", 64'(k), 64'd10);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_pops", 64'(pops), 64'd10);

    // Reset with commands in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 1), 32'd1, 4'd0, 4'(i + 8));
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    hold_prev = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale_pops", 64'(pops), 64'd0);
    chk("no_stale_busy", 64'(busy), 64'd0);

    // Divide by zero.
    drive(1'b1, 32'd9, 32'd0, 4'b0011, 4'd5);
    tick();
    cmd_valid = 1'b0;
    pops = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("divz_pop", 64'(pops), 64'd1);

    // Randomized traffic.
    k = 0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
            4'($urandom_range(0, 4)), 4'($urandom));
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      tick();
      if (last_acc) k++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
    tick();
    chk("rand_some_accepts", 64'(k > 50), 64'd1);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
